// File: rtl/cernbe_mem_responder_if.sv
// Bus bundle for the CERN-BE memory responder: VME-style word access plus a
// local read-only user port and the sticky protocol-error flag.
interface cernbe_mem_responder_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH+1:2] VMEAddr_i;
    logic [31:0]           VMEWrData_i;
    logic                  VMERdMem_i;
    logic                  VMEWrMem_i;
    logic [31:0]           VMERdData_o;
    logic                  VMERdDone_o;
    logic                  VMEWrDone_o;
    logic [ADDR_WIDTH-1:0] usr_adr_i;
    logic                  usr_rd_i;
    logic [31:0]           usr_dat_o;
    logic                  usr_ack_o;
    logic                  proto_err_o;

    modport slave (
        input  VMEAddr_i, VMEWrData_i, VMERdMem_i, VMEWrMem_i, usr_adr_i, usr_rd_i,
        output VMERdData_o, VMERdDone_o, VMEWrDone_o, usr_dat_o, usr_ack_o, proto_err_o
    );

    modport master (
        output VMEAddr_i, VMEWrData_i, VMERdMem_i, VMEWrMem_i, usr_adr_i, usr_rd_i,
        input  VMERdData_o, VMERdDone_o, VMEWrDone_o, usr_dat_o, usr_ack_o, proto_err_o
    );
endinterface

// File: rtl/cernbe_mem_responder.sv
// Single-port 32-bit memory shared by a VME-style bus (read/write) and a local
// user read port, with per-source one-deep request queues and wait states.
module cernbe_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int RD_WAIT    = 1,
    parameter int WR_WAIT    = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    cernbe_mem_responder_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUS_WR = 2'd1;
    localparam logic [1:0] BUS_RD = 2'd2;
    localparam logic [1:0] USR_RD = 2'd3;
    localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
    localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

    typedef logic [ADDR_WIDTH-1:0] adr_t;

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d, usr_pend_q, usr_pend_d;
    adr_t        wr_adr_q, wr_adr_d, rd_adr_q, rd_adr_d, usr_adr_q, usr_adr_d;
    logic [31:0] wr_dat_q, wr_dat_d;
    adr_t        act_adr_q, act_adr_d;
    logic [31:0] act_dat_q, act_dat_d;
    logic        err_q, err_d;
    logic [31:0] rd_data_q, usr_data_q;

    adr_t        vme_adr;
    logic        acc_wr, acc_rd, acc_usr;
    logic        req_wr, req_rd, req_usr;
    adr_t        wr_adr_eff, rd_adr_eff, usr_adr_eff;
    logic [31:0] wr_dat_eff;
    logic        done, start, op;
    logic [1:0]  sel, op_state;
    logic [3:0]  sel_cnt;
    adr_t        sel_adr, op_adr;
    logic [31:0] sel_dat, op_dat;
    logic        mem_we, mem_re_bus, mem_re_usr;

    assign vme_adr = bus.VMEAddr_i;

    always_comb begin
        acc_wr  = bus.VMEWrMem_i & ~wr_pend_q;
        acc_rd  = bus.VMERdMem_i & ~rd_pend_q;
        acc_usr = bus.usr_rd_i   & ~usr_pend_q;
        req_wr  = wr_pend_q  | acc_wr;
        req_rd  = rd_pend_q  | acc_rd;
        req_usr = usr_pend_q | acc_usr;

        // A request started in its own strobe cycle takes the live bus values
        wr_adr_eff  = wr_pend_q  ? wr_adr_q  : vme_adr;
        wr_dat_eff  = wr_pend_q  ? wr_dat_q  : bus.VMEWrData_i;
        rd_adr_eff  = rd_pend_q  ? rd_adr_q  : vme_adr;
        usr_adr_eff = usr_pend_q ? usr_adr_q : bus.usr_adr_i;

        wr_pend_d  = wr_pend_q  | acc_wr;
        rd_pend_d  = rd_pend_q  | acc_rd;
        usr_pend_d = usr_pend_q | acc_usr;
        wr_adr_d   = acc_wr  ? vme_adr         : wr_adr_q;
        wr_dat_d   = acc_wr  ? bus.VMEWrData_i : wr_dat_q;
        rd_adr_d   = acc_rd  ? vme_adr         : rd_adr_q;
        usr_adr_d  = acc_usr ? bus.usr_adr_i   : usr_adr_q;
        err_d      = err_q | (bus.VMEWrMem_i & wr_pend_q) | (bus.VMERdMem_i & rd_pend_q);

        sel     = IDLE;
        sel_cnt = 4'd0;
        sel_adr = act_adr_q;
        sel_dat = act_dat_q;
        if (req_wr) begin
            sel     = BUS_WR;
            sel_cnt = WR_CNT;
            sel_adr = wr_adr_eff;
            sel_dat = wr_dat_eff;
        end else if (req_rd) begin
            sel     = BUS_RD;
            sel_cnt = RD_CNT;
            sel_adr = rd_adr_eff;
        end else if (req_usr) begin
            sel     = USR_RD;
            sel_adr = usr_adr_eff;
        end

        done      = (state_q != IDLE) && (cnt_q == 4'd0);
        state_d   = state_q;
        cnt_d     = cnt_q;
        act_adr_d = act_adr_q;
        act_dat_d = act_dat_q;
        start     = 1'b0;
        op        = 1'b0;

        // The completion cycle doubles as the dispatch slot, so queued work follows with no gap
        if (state_q == IDLE || done) begin
            state_d = sel;
            cnt_d   = sel_cnt;
            if (sel != IDLE) begin
                start     = 1'b1;
                op        = (sel_cnt == 4'd0);
                act_adr_d = sel_adr;
                act_dat_d = sel_dat;
                case (sel)
                    BUS_WR:  wr_pend_d  = 1'b0;
                    BUS_RD:  rd_pend_d  = 1'b0;
                    default: usr_pend_d = 1'b0;
                endcase
            end
        end else begin
            cnt_d = cnt_q - 4'd1;
            op    = (cnt_q == 4'd1);
        end

        // The array is touched on the edge that enters an access's final cycle
        op_state   = start ? sel     : state_q;
        op_adr     = start ? sel_adr : act_adr_q;
        op_dat     = start ? sel_dat : act_dat_q;
        mem_we     = op && (op_state == BUS_WR) && !rst_i;
        mem_re_bus = op && (op_state == BUS_RD) && !rst_i;
        mem_re_usr = op && (op_state == USR_RD) && !rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            wr_pend_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            usr_pend_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_pend_q  <= wr_pend_d;
            rd_pend_q  <= rd_pend_d;
            usr_pend_q <= usr_pend_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        wr_adr_q  <= wr_adr_d;
        wr_dat_q  <= wr_dat_d;
        rd_adr_q  <= rd_adr_d;
        usr_adr_q <= usr_adr_d;
        act_adr_q <= act_adr_d;
        act_dat_q <= act_dat_d;
    end

    always_ff @(posedge clk_i) begin
        if (mem_we)
            mem[op_adr] <= op_dat;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q  <= 32'd0;
            usr_data_q <= 32'd0;
        end else begin
            if (mem_re_bus)
                rd_data_q <= mem[op_adr];
            if (mem_re_usr)
                usr_data_q <= mem[op_adr];
        end
    end

    assign bus.VMEWrDone_o = done && (state_q == BUS_WR) && !rst_i;
    assign bus.VMERdDone_o = done && (state_q == BUS_RD) && !rst_i;
    assign bus.usr_ack_o   = done && (state_q == USR_RD) && !rst_i;
    assign bus.VMERdData_o = rst_i ? 32'd0 : rd_data_q;
    assign bus.usr_dat_o   = rst_i ? 32'd0 : usr_data_q;
    assign bus.proto_err_o = err_q & ~rst_i;
endmodule

// File: tb/tb_cernbe_mem_responder.sv
// Randomised and directed bench for cernbe_mem_responder against a
// transaction-level model (finish-time server with one-deep request slots).
module tb_cernbe_mem_responder;
    localparam int AW  = 10;
    localparam int RDW = 1;
    localparam int WRW = 0;

    logic clk = 1'b0;
    logic rst1, rst2;
    always #5 clk = ~clk;

    cernbe_mem_responder_if #(.ADDR_WIDTH(AW)) b1 ();
    cernbe_mem_responder_if #(.ADDR_WIDTH(AW)) b2 ();

    cernbe_mem_responder #(.ADDR_WIDTH(AW), .RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
        .clk_i(clk), .rst_i(rst1), .bus(b1)
    );
    cernbe_mem_responder #(.ADDR_WIDTH(AW), .RD_WAIT(1), .WR_WAIT(3)) dut_slow (
        .clk_i(clk), .rst_i(rst2), .bus(b2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk1(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model of the main instance ----------------
    bit          m_on = 1'b0;
    int          cyc  = 0;
    bit          busy;
    int          fin;
    int          cur;
    logic [9:0]  ca;
    logic [31:0] cd;
    bit          pw, pr, pu;
    logic [9:0]  pwa, pra, pua;
    logic [31:0] pwd;
    bit          m_err;
    logic [31:0] last_rd, last_usr;
    bit          rd_known, usr_known;
    logic [31:0] mm [1024];
    bit          mv [1024];

    always @(negedge clk) begin
        bit ewd, erd, eack;
        if (rst1 === 1'b1) begin
            m_on = 1'b1;
            chk1 ("rst_wrdone", b1.VMEWrDone_o, 1'b0);
            chk1 ("rst_rddone", b1.VMERdDone_o, 1'b0);
            chk1 ("rst_ack",    b1.usr_ack_o,   1'b0);
            chk1 ("rst_err",    b1.proto_err_o, 1'b0);
            chk32("rst_rddata", b1.VMERdData_o, 32'd0);
            chk32("rst_usrdat", b1.usr_dat_o,   32'd0);
            busy = 0; pw = 0; pr = 0; pu = 0; m_err = 0;
            last_rd = 32'd0; last_usr = 32'd0; rd_known = 1; usr_known = 1;
        end else if (m_on) begin
            ewd = 0; erd = 0; eack = 0;
            if (busy && cyc == fin) begin
                case (cur)
                    0: begin ewd = 1; mm[ca] = cd; mv[ca] = 1; end
                    1: begin erd = 1; last_rd = mm[ca]; rd_known = mv[ca]; end
                    default: begin eack = 1; last_usr = mm[ca]; usr_known = mv[ca]; end
                endcase
                busy = 0;
            end
            chk1("m_wrdone", b1.VMEWrDone_o, ewd);
            chk1("m_rddone", b1.VMERdDone_o, erd);
            chk1("m_ack",    b1.usr_ack_o,   eack);
            chk1("m_err",    b1.proto_err_o, m_err);
            if (rd_known)  chk32("m_rddata", b1.VMERdData_o, last_rd);
            if (usr_known) chk32("m_usrdat", b1.usr_dat_o,   last_usr);
            if (b1.VMEWrMem_i) begin
                if (pw) m_err = 1;
                else begin pw = 1; pwa = b1.VMEAddr_i; pwd = b1.VMEWrData_i; end
            end
            if (b1.VMERdMem_i) begin
                if (pr) m_err = 1;
                else begin pr = 1; pra = b1.VMEAddr_i; end
            end
            if (b1.usr_rd_i && !pu) begin pu = 1; pua = b1.usr_adr_i; end
            if (!busy) begin
                if (pw)      begin busy = 1; cur = 0; ca = pwa; cd = pwd; fin = cyc + WRW + 1; pw = 0; end
                else if (pr) begin busy = 1; cur = 1; ca = pra; fin = cyc + RDW + 1; pr = 0; end
                else if (pu) begin busy = 1; cur = 2; ca = pua; fin = cyc + 1; pu = 0; end
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic drv1(input bit r, input bit w, input bit rd, input bit u,
                        input logic [9:0] a, input logic [31:0] d, input logic [9:0] ua);
        @(posedge clk); #1;
        rst1 = r; b1.VMEWrMem_i = w; b1.VMERdMem_i = rd; b1.usr_rd_i = u;
        b1.VMEAddr_i = a; b1.VMEWrData_i = d; b1.usr_adr_i = ua;
        #2;
    endtask

    task automatic idle1();
        drv1(1'b0, 1'b0, 1'b0, 1'b0, 10'($urandom), $urandom, 10'($urandom));
    endtask

    task automatic drv2(input bit r, input bit w, input bit rd,
                        input logic [9:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        rst2 = r; b2.VMEWrMem_i = w; b2.VMERdMem_i = rd; b2.usr_rd_i = 1'b0;
        b2.VMEAddr_i = a; b2.VMEWrData_i = d; b2.usr_adr_i = 10'd0;
        #2;
    endtask

    task automatic chk_slow_zero(input string tag);
        chk1 ({tag, "_wrdone"}, b2.VMEWrDone_o, 1'b0);
        chk1 ({tag, "_rddone"}, b2.VMERdDone_o, 1'b0);
        chk1 ({tag, "_ack"},    b2.usr_ack_o,   1'b0);
        chk1 ({tag, "_err"},    b2.proto_err_o, 1'b0);
        chk32({tag, "_rddata"}, b2.VMERdData_o, 32'd0);
        chk32({tag, "_usrdat"}, b2.usr_dat_o,   32'd0);
    endtask

    function automatic logic [31:0] sweep_val(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
    endfunction

    initial begin
        int cnt;
        rst1 = 1'b1; rst2 = 1'b1;
        b1.VMEWrMem_i = 0; b1.VMERdMem_i = 0; b1.usr_rd_i = 0;
        b1.VMEAddr_i = '0; b1.VMEWrData_i = '0; b1.usr_adr_i = '0;
        b2.VMEWrMem_i = 0; b2.VMERdMem_i = 0; b2.usr_rd_i = 0;
        b2.VMEAddr_i = '0; b2.VMEWrData_i = '0; b2.usr_adr_i = '0;

        drv1(1'b1, 0, 0, 0, 10'd0, 32'd0, 10'd0);
        drv1(1'b1, 0, 0, 0, 10'd0, 32'd0, 10'd0);
        idle1();

        // write then read of one word
        drv1(1'b0, 1, 0, 0, 10'h005, 32'hDEADBEEF, 10'd0);
        idle1(); chk1("wr_done_t1", b1.VMEWrDone_o, 1'b1);
        idle1(); chk1("wr_done_once", b1.VMEWrDone_o, 1'b0);
        drv1(1'b0, 0, 1, 0, 10'h005, 32'd0, 10'd0);
        idle1(); chk1("rd_done_early", b1.VMERdDone_o, 1'b0);
        idle1(); chk1("rd_done_t2", b1.VMERdDone_o, 1'b1);
        chk32("rd_data_t2", b1.VMERdData_o, 32'hDEADBEEF);
        idle1(); chk32("rd_data_hold", b1.VMERdData_o, 32'hDEADBEEF);

        // simultaneous write and read of the same word
        drv1(1'b0, 1, 1, 0, 10'h010, 32'h12345678, 10'd0);
        idle1(); chk1("wr_rd_wrdone", b1.VMEWrDone_o, 1'b1);
        idle1(); chk1("wr_rd_rd_wait", b1.VMERdDone_o, 1'b0);
        idle1(); chk1("wr_rd_rddone", b1.VMERdDone_o, 1'b1);
        chk32("wr_rd_data", b1.VMERdData_o, 32'h12345678);

        // bus read and user read together: bus first
        drv1(1'b0, 0, 1, 1, 10'h005, 32'd0, 10'h010);
        idle1(); chk1("usr_wait1", b1.usr_ack_o, 1'b0);
        idle1(); chk1("bus_first_done", b1.VMERdDone_o, 1'b1);
        chk32("bus_first_data", b1.VMERdData_o, 32'hDEADBEEF);
        chk1("usr_wait2", b1.usr_ack_o, 1'b0);
        idle1(); chk1("usr_ack_t3", b1.usr_ack_o, 1'b1);
        chk32("usr_data_t3", b1.usr_dat_o, 32'h12345678);
        chk1("usr_no_err", b1.proto_err_o, 1'b0);

        // duplicate read strobe while one is queued
        drv1(1'b0, 1, 1, 0, 10'h020, 32'hA5A50001, 10'd0);
        drv1(1'b0, 0, 1, 0, 10'h020, 32'd0, 10'd0);
        cnt = int'(b1.VMERdDone_o);
        for (int k = 0; k < 6; k++) begin idle1(); cnt += int'(b1.VMERdDone_o); end
        chk32("dup_rd_count", 32'(cnt), 32'd1);
        chk1("dup_err_set", b1.proto_err_o, 1'b1);
        idle1(); chk1("dup_err_sticky", b1.proto_err_o, 1'b1);
        drv1(1'b1, 0, 0, 0, 10'd0, 32'd0, 10'd0);
        idle1(); chk1("err_cleared", b1.proto_err_o, 1'b0);

        // randomised traffic, small address window to force hits
        for (int blk = 0; blk < 3; blk++) begin
            for (int k = 0; k < 500; k++) begin
                drv1(1'b0, ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                     ($urandom_range(2) == 0), 10'($urandom_range(15)), $urandom,
                     10'($urandom_range(15)));
            end
            for (int k = 0; k < 8; k++) idle1();
            drv1(1'b1, 0, 0, 0, 10'd0, 32'd0, 10'd0);
            idle1();
        end

        // full-depth sweep: back-to-back writes, then reads
        cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            drv1(1'b0, 1, 0, 0, 10'(i), sweep_val(i), 10'd0);
            cnt += int'(b1.VMEWrDone_o);
        end
        idle1(); cnt += int'(b1.VMEWrDone_o);
        chk32("sweep_wr_done_count", 32'(cnt), 32'd1024);
        for (int i = 0; i < 1024; i++) begin
            drv1(1'b0, 0, 1, 0, 10'(i), $urandom, 10'd0);
            idle1();
            idle1();
            if (i % 128 == 0) chk32("sweep_rd_pin", b1.VMERdData_o, sweep_val(i));
        end

        // slow-write instance: reset aborts an in-flight write
        drv2(1'b1, 0, 0, 10'd0, 32'd0);
        chk_slow_zero("slow_rst");
        drv2(1'b0, 0, 0, 10'd0, 32'd0);
        drv2(1'b0, 1, 0, 10'h007, 32'h0BADF00D);
        for (int k = 1; k <= 4; k++) begin
            drv2(1'b0, 0, 0, 10'($urandom), $urandom);
            chk1("slow_wr_done", b2.VMEWrDone_o, (k == 4));
        end
        drv2(1'b0, 1, 0, 10'h007, 32'hFFFF0000);
        drv2(1'b1, 0, 0, 10'd0, 32'd0);
        chk_slow_zero("abort_rstcyc");
        drv2(1'b0, 0, 0, 10'd0, 32'd0);
        chk_slow_zero("abort_after");
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            drv2(1'b0, 0, 0, 10'd0, 32'd0);
            cnt += int'(b2.VMEWrDone_o);
        end
        chk32("abort_no_done", 32'(cnt), 32'd0);
        drv2(1'b0, 0, 1, 10'h007, 32'd0);
        drv2(1'b0, 0, 0, 10'd0, 32'd0);
        drv2(1'b0, 0, 0, 10'd0, 32'd0);
        chk1("abort_rd_done", b2.VMERdDone_o, 1'b1);
        chk32("abort_word_kept", b2.VMERdData_o, 32'h0BADF00D);

        idle1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cernbe_mem_responder.md
CERNBE_MEM_RESPONDER -- requirements
Module: cernbe_mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: number of word-address bits; memory depth is 2**ADDR_WIDTH words of 32 bits.
REQ-002 Parameter RD_WAIT, default 1, range 0..15: extra read wait cycles.
REQ-003 Parameter WR_WAIT, default 0, range 0..15: extra write wait cycles.
REQ-004 clk_i  in  1  single clock; all logic is on its rising edge.
REQ-005 rst_i  in  1  reset; synchronous, active-high.
REQ-006 VMEAddr_i  in  ADDR_WIDTH (bits [ADDR_WIDTH+1:2])  CERN-BE word address.
REQ-007 VMEWrData_i  in  32  write data.
REQ-008 VMERdMem_i  in  1  read strobe, one-cycle pulse.
REQ-009 VMEWrMem_i  in  1  write strobe, one-cycle pulse.
REQ-010 VMERdData_o  out  32  read data; valid only in the VMERdDone_o cycle.
REQ-011 VMERdDone_o  out  1  read completion, one-cycle pulse.
REQ-012 VMEWrDone_o  out  1  write completion, one-cycle pulse.
REQ-013 usr_adr_i  in  ADDR_WIDTH  local read-port address.
REQ-014 usr_rd_i  in  1  local read request, one-cycle pulse.
REQ-015 usr_dat_o  out  32  local read data; valid only in the usr_ack_o cycle.
REQ-016 usr_ack_o  out  1  local read completion, one-cycle pulse.
REQ-017 proto_err_o  out  1  sticky protocol-error flag.

Function
REQ-018 Address and write data are captured in the strobe cycle; later changes on VMEAddr_i and VMEWrData_i do not affect the access.
REQ-019 Storage is a single-port, synchronous-read array; at most one access (bus read, bus write or user read) is performed per cycle.
REQ-020 FSM states: IDLE, BUS_WR, BUS_RD, USR_RD.
- Priority from IDLE: pending write > pending read > pending user read.
- Each access state loads a wait counter (WR_WAIT, RD_WAIT, or 0 for user) and decrements it to 0.
- When the counter is 0 the access is performed, the Done/ack pulse is issued, and the FSM returns to IDLE.
REQ-021 Uncontended write: the array is updated and VMEWrDone_o pulses WR_WAIT+1 cycles after the VMEWrMem_i cycle.
REQ-022 Uncontended read: VMERdDone_o pulses with VMERdData_o = mem[addr] RD_WAIT+1 cycles after the VMERdMem_i cycle.
REQ-023 Uncontended user read: usr_ack_o pulses with data 1 cycle after the usr_rd_i cycle.
REQ-024 Each source (bus write, bus read, user read) has a one-deep pending register, set by its strobe and cleared when its access starts; a strobe arriving while busy is queued there.
REQ-025 Simultaneous VMEWrMem_i and VMERdMem_i: the write is served first and the read follows immediately. A read to the same address returns the new data.
REQ-026 A bus strobe arriving while the same source's pending register is already set is dropped and sets proto_err_o. proto_err_o clears only on reset.
REQ-027 A user request arriving while the user pending register is set is dropped and does not set proto_err_o.
REQ-028 The bus always has priority; user reads are served only when no bus request is pending.
REQ-029 VMERdData_o and usr_dat_o hold their last value outside the Done/ack cycle.
REQ-030 Done pulses never exceed one cycle per accepted strobe; no Done is issued for a dropped strobe.

Reset
REQ-031 In any reset cycle:
- FSM goes to IDLE.
- Counters, pending registers and proto_err_o clear to 0.
- VMERdDone_o, VMEWrDone_o and usr_ack_o are 0.
- VMERdData_o and usr_dat_o are 0.
REQ-032 Reset mid-access aborts the access with no Done/ack pulse and no array write. Array contents are not initialised by reset.

Verification
REQ-033 RD_WAIT=1, WR_WAIT=0: write 0xDEADBEEF to addr 0x005 at cycle t -> VMEWrDone_o at t+1; read addr 0x005 -> VMERdDone_o at read cycle+2 with data 0xDEADBEEF.
REQ-034 Simultaneous write (addr 0x010, data 0x12345678) and read (addr 0x010) at cycle t -> VMEWrDone_o at t+1, VMERdDone_o at t+3 with 0x12345678.
REQ-035 usr_rd_i and VMERdMem_i in the same cycle t -> bus read completes first (t+2), usr_ack_o at t+3; proto_err_o stays 0.
REQ-036 Second VMERdMem_i while a read is pending and the FSM is busy -> exactly one VMERdDone_o and proto_err_o=1 until rst_i.
REQ-037 rst_i asserted one cycle after VMEWrMem_i with WR_WAIT=3 -> no VMEWrDone_o, target word unchanged, all outputs 0 in the following cycle.
REQ-038 Back-to-back writes to 0x000..0x3FF followed by reads -> every read returns the written value, one Done per strobe.
